execute: RTL and testbench

EXECUTE -- requirements
Module: execute

---
 rtl/execute.sv | 139 +++++++++++++
 tb/tb_execute.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/execute.sv
// Execute unit: repeated INC/DEC on cell or pointer, OUT/IN handshakes, JZ/JNZ test.
// Optional macro EXECUTE_SAT_EN: cell INC/DEC saturate at FF/00 instead of wrapping.
module execute #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] cnt,
  input  logic [7:0]       a_in,
  input  logic [7:0]       b_in,
  output logic             busy,
  output logic             wb_en,
  output logic [1:0]       wb_op,
  output logic             wb_srcdst,
  output logic [7:0]       wb_val,
  output logic             branch_taken,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ack,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ack
);

  // state   | meaning
  // IDLE    | waiting for en, operands not yet latched
  // EXEC    | one INC/DEC step per cycle until rem reaches zero
  // IO_WAIT | OUT waits for out_ack, IN waits for in_valid
  // DONE    | single writeback cycle (wb_en=1)
  typedef enum logic [1:0] {IDLE, EXEC, IO_WAIT, DONE} state_t;

  localparam logic [2:0] OP_INC_A = 3'b000;
  localparam logic [2:0] OP_DEC_A = 3'b001;
  localparam logic [2:0] OP_INC_B = 3'b010;
  localparam logic [2:0] OP_DEC_B = 3'b011;
  localparam logic [2:0] OP_OUT   = 3'b100;
  localparam logic [2:0] OP_IN    = 3'b101;
  localparam logic [2:0] OP_JZ    = 3'b110;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [7:0]       work_q, work_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [7:0]       step_val;
  logic             is_inc, is_cell;

  assign is_inc  = ~op_q[0];
  assign is_cell = ~op_q[1];

  always_comb begin
    step_val = is_inc ? work_q + 8'd1 : work_q - 8'd1;
`ifdef EXECUTE_SAT_EN
    // Only the cell saturates; the pointer always wraps.
    if (is_cell && is_inc && (work_q == 8'hFF)) step_val = 8'hFF;
    if (is_cell && !is_inc && (work_q == 8'h00)) step_val = 8'h00;
`endif
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    work_d       = work_q;
    rem_d        = rem_q;
    wb_en        = 1'b0;
    wb_op        = 2'b00;
    wb_srcdst    = 1'b0;
    wb_val       = 8'h00;
    branch_taken = 1'b0;
    out_data     = 8'h00;
    out_valid    = 1'b0;
    in_ack       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          op_d   = op;
          work_d = (op == OP_INC_B || op == OP_DEC_B) ? b_in : a_in;
          rem_d  = op[2] ? '0 : cnt;
          if (!op[2])      state_d = EXEC;
          else if (!op[1]) state_d = IO_WAIT;
          else             state_d = DONE;
        end
      end
      EXEC: begin
        work_d = step_val;
        rem_d  = rem_q - 1'b1;
        if (rem_q == '0) state_d = DONE;
      end
      IO_WAIT: begin
        if (op_q == OP_OUT) begin
          out_valid = 1'b1;
          out_data  = work_q;
          if (out_ack) state_d = DONE;
        end else if (in_valid) begin
          in_ack  = 1'b1;
          work_d  = in_data;
          state_d = DONE;
        end
      end
      DONE: begin
        wb_en   = 1'b1;
        state_d = IDLE;
        unique case (op_q)
          OP_INC_A, OP_DEC_A, OP_IN: begin
            wb_op     = 2'b01;
            wb_srcdst = 1'b1;
            wb_val    = work_q;
          end
          OP_INC_B, OP_DEC_B: begin
            wb_op  = 2'b01;
            wb_val = work_q;
          end
          OP_JZ:   branch_taken = (work_q == 8'h00);
          3'b111:  branch_taken = (work_q != 8'h00);
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      work_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_execute.sv
// Scoreboard bench for execute: driver pushes expected writebacks, monitor pops on wb_en.
module tb_execute;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, en;
  logic [2:0]       op;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       a_in, b_in;
  logic             busy, wb_en, wb_srcdst, branch_taken, out_valid, out_ack;
  logic [1:0]       wb_op;
  logic [7:0]       wb_val, out_data, in_data;
  logic             in_valid, in_ack;

  execute #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .cnt(cnt), .a_in(a_in), .b_in(b_in),
    .busy(busy), .wb_en(wb_en), .wb_op(wb_op), .wb_srcdst(wb_srcdst), .wb_val(wb_val),
    .branch_taken(branch_taken), .out_data(out_data), .out_valid(out_valid),
    .out_ack(out_ack), .in_data(in_data), .in_valid(in_valid), .in_ack(in_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] wop;
    logic       sd;
    logic [7:0] val;
    logic       br;
    int         due;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: net effect of an op from the architectural rules.
  function automatic exp_t model(input logic [2:0] o, input int n_cnt,
                                 input int a, input int b, input int din);
    exp_t r;
    int   n, v;
    n = n_cnt + 1;
    r.wop = 2'b00; r.sd = 1'b0; r.val = 8'h00; r.br = 1'b0; r.due = -1;
    case (o)
      3'd0: begin
        v = a + n;
`ifdef EXECUTE_SAT_EN
        if (v > 255) v = 255;
`endif
        r.wop = 2'b01; r.sd = 1'b1; r.val = 8'(v % 256);
      end
      3'd1: begin
        v = a - n;
`ifdef EXECUTE_SAT_EN
        if (v < 0) v = 0;
`endif
        r.wop = 2'b01; r.sd = 1'b1; r.val = 8'((v + 512) % 256);
      end
      3'd2: begin r.wop = 2'b01; r.val = 8'((b + n) % 256); end
      3'd3: begin r.wop = 2'b01; r.val = 8'((b - n + 512) % 256); end
      3'd5: begin r.wop = 2'b01; r.sd = 1'b1; r.val = 8'(din); end
      3'd6: r.br = (a == 0);
      3'd7: r.br = (a != 0);
      default: ;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (wb_en) begin
        if (sbq.size() == 0) begin
          chk("unexpected_wb_en", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("wb_op", wb_op, mon_e.wop);
          if (mon_e.wop == 2'b01) begin
            chk("wb_srcdst", wb_srcdst, mon_e.sd);
            chk("wb_val", wb_val, mon_e.val);
          end
          chk("branch_taken", branch_taken, mon_e.br);
          if (mon_e.due >= 0) chk("wb_latency", cyc, mon_e.due);
        end
      end else begin
        chk("quiet_wb_fields", {branch_taken, wb_val, wb_op, wb_srcdst}, 0);
      end
    end
  end

  // hold: cycles of out_ack=0 / in_valid=0 before the handshake.
  task automatic issue(input logic [2:0] o, input int c, input int a, input int b,
                       input int hold, input int din);
    exp_t e;
    int   acc;
    bit   ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("busy_timeout", 1, 0);
    en = 1'b1; op = o; cnt = CNT_W'(c); a_in = 8'(a); b_in = 8'(b);
    e = model(o, c, a, b, din);
    @(posedge clk);
    #1;
    acc = cyc;
    if (o < 3'd4)      e.due = acc + c + 1;
    else if (o >= 3'd6) e.due = acc;
    sbq.push_back(e);
    // Garbage start requests while busy must be ignored.
    en = 1'($urandom_range(0, 1)); op = 3'($urandom); cnt = CNT_W'($urandom);
    a_in = 8'($urandom); b_in = 8'($urandom);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (wb_en) begin
        en = 1'b0; out_ack = 1'b0; in_valid = 1'b0;
        ok = 1'b1;
        break;
      end
      if (o == 3'd4) begin
        chk("out_valid", out_valid, 1);
        chk("out_data", out_data, a);
        out_ack = (i == hold);
      end else if (o == 3'd5) begin
        in_valid = (i == hold);
        in_data  = (i == hold) ? 8'(din) : 8'($urandom);
        #1;
        chk("in_ack", in_ack, (i == hold) ? 1 : 0);
      end
    end
    if (!ok) chk("wb_timeout", 1, 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; op = '0; cnt = '0; a_in = '0; b_in = '0;
    out_ack = 1'b0; in_data = '0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_out", {out_valid, out_data}, 0);
    chk("rst_in_ack", in_ack, 0);
    rst = 1'b0;

    issue(3'd0, 0, 8'h05, 0, 0, 0);
    issue(3'd1, 3, 8'h02, 0, 0, 0);
    issue(3'd3, 0, 0, 8'h00, 0, 0);
    issue(3'd2, 0, 0, 8'hFF, 0, 0);
    issue(3'd0, 2, 8'hFE, 0, 0, 0);
    issue(3'd4, 9, 8'h41, 0, 5, 0);
    issue(3'd5, 7, 8'h10, 0, 3, 8'hA5);
    issue(3'd6, 0, 8'h00, 0, 0, 0);
    issue(3'd6, 0, 8'h07, 0, 0, 0);
    issue(3'd7, 0, 8'h00, 0, 0, 0);
    issue(3'd7, 0, 8'h07, 0, 0, 0);

    for (int k = 0; k < 150; k++)
      issue(3'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 4)),
            int'($urandom_range(0, 255)));

    // Abort an IN mid-wait with reset; later in_valid must be ignored.
    @(negedge clk);
    en = 1'b1; op = 3'd5; a_in = 8'h33;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("in_wait_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b1; in_data = 8'h77;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_in_ack", in_ack, 0);
    end
    in_valid = 1'b0;

    // Reset dominates en at the same edge.
    @(negedge clk);
    en = 1'b1; op = 3'd0; cnt = '0; rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; en = 1'b0;
    @(negedge clk);
    chk("rst_over_en_busy", busy, 0);
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
